// File: rtl/ctr_addr_gen.sv
// Two-field {rg_a, bit_a} address walker for serial register-bit scanning.
// Supports enable, up/down, parallel load, sync clear, and wrap-or-stop terminal handling.
//
// state | meaning
// RUN   | counting allowed, halted=0
// HALT  | parked at terminal address after a stop-mode step, halted=1
module ctr_addr_gen #(
    parameter int RG_W    = 4,
    parameter int BIT_W   = 2,
    parameter int RG_LAST = 15
) (
    input  logic             tick,
    input  logic             clr_n,
    input  logic             en,
    input  logic             up,
    input  logic             stop_mode,
    input  logic             sclr,
    input  logic             load,
    input  logic [RG_W-1:0]  load_rg,
    input  logic [BIT_W-1:0] load_bit,
    output logic [RG_W-1:0]  rg_a,
    output logic [BIT_W-1:0] bit_a,
    output logic             tc,
    output logic             wrap,
    output logic             halted
);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    localparam logic [RG_W-1:0]  RG_LAST_V = RG_W'(RG_LAST);
    localparam logic [BIT_W-1:0] BIT_MAX   = {BIT_W{1'b1}};

    state_t           state, state_nxt;
    logic [RG_W-1:0]  rg_nxt;
    logic [BIT_W-1:0] bit_nxt;
    logic             wrap_nxt;
    logic             at_top;
    logic             at_bot;

    assign at_top = (rg_a == RG_LAST_V) && (bit_a == BIT_MAX);
    assign at_bot = (rg_a == '0) && (bit_a == '0);
    assign tc     = up ? at_top : at_bot;
    assign halted = (state == HALT);

    always_ff @(posedge tick or negedge clr_n) begin
        if (!clr_n) begin
            state <= RUN;
            rg_a  <= '0;
            bit_a <= '0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            rg_a  <= rg_nxt;
            bit_a <= bit_nxt;
            wrap  <= wrap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rg_nxt    = rg_a;
        bit_nxt   = bit_a;
        wrap_nxt  = 1'b0;
        if (sclr) begin
            state_nxt = RUN;
            rg_nxt    = '0;
            bit_nxt   = '0;
        end else if (load) begin
            state_nxt = RUN;
            // Out-of-range loads clamp so rg_a never leaves the valid depth
            rg_nxt    = (load_rg > RG_LAST_V) ? RG_LAST_V : load_rg;
            bit_nxt   = load_bit;
        end else begin
            case (state)
                RUN: begin
                    if (en) begin
                        if (tc) begin
                            if (stop_mode) begin
                                state_nxt = HALT;
                            end else begin
                                wrap_nxt = 1'b1;
                                rg_nxt   = up ? '0 : RG_LAST_V;
                                bit_nxt  = up ? '0 : BIT_MAX;
                            end
                        end else if (up) begin
                            if (bit_a == BIT_MAX) begin
                                bit_nxt = '0;
                                rg_nxt  = rg_a + 1'b1;
                            end else begin
                                bit_nxt = bit_a + 1'b1;
                            end
                        end else begin
                            if (bit_a == '0) begin
                                bit_nxt = BIT_MAX;
                                rg_nxt  = rg_a - 1'b1;
                            end else begin
                                bit_nxt = bit_a - 1'b1;
                            end
                        end
                    end
                end
                HALT: state_nxt = HALT;
                default: state_nxt = RUN;
            endcase
        end
    end

endmodule

// File: doc/ctr_addr_gen.md
Name: ctr_addr_gen

Overview:
- Parametrised successor to the 64-position register/bit address counter.
- Walks a two-field address {rg_a, bit_a} over a configurable depth.
- Adds count enable, up/down direction, parallel load, synchronous clear, and wrap-or-stop terminal modes, plus terminal-count and wrap status.
- Feeds register-file/bit-select logic that scans register bits serially.

Parameters:
RG_W, 4, width of register-address field rg_a
BIT_W, 2, width of bit-address field bit_a; bit field always spans 0..2^BIT_W-1
RG_LAST, 15, highest valid register index (1..2^RG_W-1); sets non-power-of-two depth

Ports:
tick  in  1  clock, rising edge active
clr_n  in  1  asynchronous active-low reset
en  in  1  advance address by one step this cycle
up  in  1  direction: 1 = increment, 0 = decrement
stop_mode  in  1  1 = halt at terminal address, 0 = wrap around
sclr  in  1  synchronous clear to address 0
load  in  1  synchronous parallel load
load_rg  in  RG_W  register index to load
load_bit  in  BIT_W  bit index to load
rg_a  out  RG_W  current register address (registered)
bit_a  out  BIT_W  current bit address (registered)
tc  out  1  combinational: address is terminal for current direction
wrap  out  1  registered one-cycle pulse: wrap just occurred
halted  out  1  registered sticky flag: stopped at terminal address

Behaviour:
- Reset: clr_n low forces rg_a=0, bit_a=0, wrap=0, halted=0 immediately, with no dependence on tick. Release is synchronous-safe: the first update happens on the first tick edge with clr_n high.
- Priority per edge, highest first:
  - sclr: rg_a=0, bit_a=0, halted=0, wrap=0.
  - load: rg_a=min(load_rg, RG_LAST), bit_a=load_bit, halted=0, wrap=0.
  - en & !halted: step.
  - Otherwise: hold. wrap=0 on every non-wrapping edge.
- Step up:
  - bit_a<max: bit_a+1.
  - Else bit_a=0 and rg_a+1.
  - From {RG_LAST, max}: if stop_mode=0, go to {0,0} and set wrap=1 for one cycle. If stop_mode=1, hold and set halted=1.
- Step down:
  - bit_a>0: bit_a-1.
  - Else bit_a=max and rg_a-1.
  - From {0,0}: if stop_mode=0, go to {RG_LAST, max} and set wrap=1. If stop_mode=1, hold and set halted=1.
- tc:
  - up=1: tc=1 when rg_a==RG_LAST and bit_a==max.
  - up=0: tc=1 when rg_a==0 and bit_a==0.
- halted:
  - Blocks en until sclr or load.
  - Changing up or stop_mode does not clear it.
- rg_a never exceeds RG_LAST under any stimulus, including out-of-range load.
- sclr and load asserted together: sclr wins.
- clr_n asserted mid-count or while halted: full reset, and halted clears.
- Control state: RUN (halted=0) and HALT (halted=1).
  - RUN -> HALT on a stop-mode terminal step.
  - HALT -> RUN on sclr or load.
- Full period in wrap mode = (RG_LAST+1)*2^BIT_W en cycles.

Test Plan:
- Reset and up-count, defaults, stop_mode=0, en=1 for 64 ticks:
  - Addresses step {0,0},{0,1}..{15,3}.
  - tc=1 only at {15,3}.
  - 64th tick returns to {0,0} with wrap=1 for exactly one cycle.
- RG_LAST=9, stop_mode=1, up=1, en=1 for 45 ticks:
  - Reaches {9,3} at tick 39.
  - halted=1 after tick 40, address holds {9,3}, wrap never pulses.
  - load {2,1} clears halted, and the next en tick gives {2,2}.
- Down wrap, up=0, stop_mode=0 from {0,0}, one en tick:
  - Address becomes {RG_LAST,3} and wrap pulses.
  - Next tick gives {RG_LAST,2}.
- Load/clear priority:
  - load_rg=15 with RG_LAST=9 loads rg_a=9.
  - sclr=1, load=1, en=1 on the same edge gives {0,0}.
  - en=0 holds the address for 5 ticks.
- Async reset mid-count: at {7,2} with halted=0, pulse clr_n low between edges.
  - Outputs go to 0 before the next edge.
  - Counting resumes from {0,0} on the first edge after release.
